// File: rtl/breath_pkg.sv
// ---------------------------------------------------------------------------
// breath_pkg
// Shared definitions for the breathing-LED envelope generator:
//   - state encoding of the envelope FSM (3 bits; IDLE..HOLD_LO)
//   - default timing / level constants
//   - STEP_W, width of the runtime step and hold inputs
//   - cnt_width(), counter width helper that never returns 0
// ---------------------------------------------------------------------------
package breath_pkg;

    localparam int STEP_W          = 8;
    localparam int CLK_DIV_DEF     = 50;    // clk cycles per PWM tick
    localparam int FRAME_TICKS_DEF = 1000;  // ticks per PWM frame
    localparam int LEVEL_W_DEF     = 10;
    localparam int LEVEL_MAX_DEF   = 999;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_e;

    // Width of a counter covering 0..n-1; at least 1 bit so n=1 still builds.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/breath_env_gen_if.sv
// ---------------------------------------------------------------------------
// breath_env_gen_if
// Control/output bundle of the envelope generator.
//   en_i, step_i, hold_hi_i, hold_lo_i : runtime controls (master drives)
//   duty_o, frame_o, state_o, busy_o   : envelope outputs (slave drives)
//   frame_cnt_o                        : shared in-frame tick index, so the
//                                        PWM stage can use the same timebase
// Parameters: LEVEL_W (duty width), FCNT_W (frame counter width).
// ---------------------------------------------------------------------------
interface breath_env_gen_if #(
    parameter int LEVEL_W = 10,
    parameter int FCNT_W  = 10
);
    logic               en_i;
    logic [7:0]         step_i;
    logic [7:0]         hold_hi_i;
    logic [7:0]         hold_lo_i;
    logic [LEVEL_W-1:0] duty_o;
    logic               frame_o;
    logic [2:0]         state_o;
    logic               busy_o;
    logic [FCNT_W-1:0]  frame_cnt_o;

    modport master (
        output en_i, step_i, hold_hi_i, hold_lo_i,
        input  duty_o, frame_o, state_o, busy_o, frame_cnt_o
    );

    modport slave (
        input  en_i, step_i, hold_hi_i, hold_lo_i,
        output duty_o, frame_o, state_o, busy_o, frame_cnt_o
    );
endinterface

// File: rtl/breath_frame_tb.sv
// ---------------------------------------------------------------------------
// breath_frame_tb
// PWM timebase: tick_cnt counts 0..CLK_DIV-1, frame_cnt advances on every
// tick wrap and counts 0..FRAME_TICKS-1.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   fb_o         : combinational frame boundary (both counters at maximum)
//   frame_cnt_o  : current tick index inside the frame
// ---------------------------------------------------------------------------
module breath_frame_tb
    import breath_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int FRAME_TICKS = FRAME_TICKS_DEF,
    parameter int FCNT_W      = cnt_width(FRAME_TICKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fb_o,
    output logic [FCNT_W-1:0] frame_cnt_o
);
    localparam int TICK_W = cnt_width(CLK_DIV);
    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(CLK_DIV - 1);
    localparam logic [FCNT_W-1:0] FRAME_MAX = FCNT_W'(FRAME_TICKS - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [FCNT_W-1:0] frame_q, frame_d;
    logic              tick_wrap;
    logic              frame_wrap;

    always_comb begin
        tick_wrap  = (tick_q == TICK_MAX);
        frame_wrap = (frame_q == FRAME_MAX);
        tick_d     = tick_wrap ? '0 : tick_q + 1'b1;
        frame_d    = frame_q;
        if (tick_wrap) begin
            frame_d = frame_wrap ? '0 : frame_q + 1'b1;
        end
        fb_o = tick_wrap && frame_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q  <= '0;
            frame_q <= '0;
        end else begin
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign frame_cnt_o = frame_q;

endmodule

// File: rtl/breath_env_gen.sv
// ---------------------------------------------------------------------------
// breath_env_gen
// Breathing envelope: once per PWM frame the level moves through
// rise -> hold-high -> fall -> hold-low; duty_o is registered on the frame
// boundary together with the frame_o strobe and stays stable all frame.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : breath_env_gen_if.slave (controls in, duty/frame/state out)
// Build option: define BREATH_GAMMA_EN to output (level*level) >> LEVEL_W
// instead of the linear level (approximate gamma 2); timing is unchanged.
// ---------------------------------------------------------------------------
module breath_env_gen
    import breath_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int FRAME_TICKS = FRAME_TICKS_DEF,
    parameter int LEVEL_W     = LEVEL_W_DEF,
    parameter int LEVEL_MAX   = LEVEL_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    breath_env_gen_if.slave bus
);
    localparam int FCNT_W = cnt_width(FRAME_TICKS);
    // One spare bit so level+step can be compared against the peak without wrap.
    localparam int SUM_W  = ((LEVEL_W > STEP_W) ? LEVEL_W : STEP_W) + 1;
    localparam logic [SUM_W-1:0]   MAX_EXT = SUM_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(LEVEL_MAX);

    logic              fb;
    logic [FCNT_W-1:0] frame_cnt;

    breath_frame_tb #(
        .CLK_DIV     (CLK_DIV),
        .FRAME_TICKS (FRAME_TICKS),
        .FCNT_W      (FCNT_W)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .fb_o        (fb),
        .frame_cnt_o (frame_cnt)
    );

    state_e              state_q, state_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [STEP_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [LEVEL_W-1:0]  duty_q, duty_d;
    logic                frame_q;

    logic [SUM_W-1:0]    step_eff;
    logic [SUM_W-1:0]    lvl_ext;
    logic [SUM_W-1:0]    sum;
    state_e              start_state;
    logic [LEVEL_W-1:0]  start_level;
    logic [LEVEL_W-1:0]  shaped;

    // Starting a breath from zero: a step that already reaches the peak goes
    // straight to HOLD_HI instead of overshooting.
    always_comb begin
        step_eff = (bus.step_i == '0) ? SUM_W'(1) : SUM_W'(bus.step_i);
        lvl_ext  = SUM_W'(level_q);
        sum      = lvl_ext + step_eff;
        if (step_eff >= MAX_EXT) begin
            start_state = HOLD_HI;
            start_level = MAX_LVL;
        end else begin
            start_state = RISE;
            start_level = step_eff[LEVEL_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (fb) begin
                    level_d = '0;
                    if (bus.en_i) begin
                        state_d    = start_state;
                        level_d    = start_level;
                        hold_cnt_d = bus.hold_hi_i;
                    end
                end
            end
            RISE: begin
                if (fb) begin
                    if (!bus.en_i) begin
                        state_d = FALL;
                    end else if (sum >= MAX_EXT) begin
                        state_d    = HOLD_HI;
                        level_d    = MAX_LVL;
                        hold_cnt_d = bus.hold_hi_i;
                    end else begin
                        level_d = sum[LEVEL_W-1:0];
                    end
                end
            end
            HOLD_HI: begin
                if (fb) begin
                    if (!bus.en_i || hold_cnt_q == '0) begin
                        state_d = FALL;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
            end
            FALL: begin
                // en_i is not looked at: a started fall always reaches zero.
                if (fb) begin
                    if (lvl_ext <= step_eff) begin
                        state_d    = HOLD_LO;
                        level_d    = '0;
                        hold_cnt_d = bus.hold_lo_i;
                    end else begin
                        level_d = LEVEL_W'(lvl_ext - step_eff);
                    end
                end
            end
            HOLD_LO: begin
                if (fb) begin
                    level_d = '0;
                    if (hold_cnt_q == '0) begin
                        if (bus.en_i) begin
                            state_d    = start_state;
                            level_d    = start_level;
                            hold_cnt_d = bus.hold_hi_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                // Unused encodings fall back to IDLE without waiting for fb.
                state_d    = IDLE;
                level_d    = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

`ifdef BREATH_GAMMA_EN
    logic [2*LEVEL_W-1:0] level_sq;
    assign level_sq = (2*LEVEL_W)'(level_d) * (2*LEVEL_W)'(level_d);
    assign shaped   = level_sq[2*LEVEL_W-1:LEVEL_W];
`else
    assign shaped   = level_d;
`endif

    // Duty is taken from the level being written at fb so it lands on the
    // same edge frame_o rises.
    always_comb begin
        duty_d = duty_q;
        if (fb) begin
            duty_d = shaped;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            level_q    <= '0;
            hold_cnt_q <= '0;
            duty_q     <= '0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            hold_cnt_q <= hold_cnt_d;
            duty_q     <= duty_d;
            frame_q    <= fb;
        end
    end

    assign bus.duty_o      = duty_q;
    assign bus.frame_o     = frame_q;
    assign bus.state_o     = state_q;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_breath_env_gen.sv
// ---------------------------------------------------------------------------
// tb_breath_env_gen
// Directed bench for breath_env_gen with a short frame (CLK_DIV=2,
// FRAME_TICKS=4, LEVEL_MAX=20). A table of per-frame inputs and expected
// level/state drives the main envelope; reset and frame timing are checked
// with hand-written sequences.
// ---------------------------------------------------------------------------
module tb_breath_env_gen;
    import breath_pkg::*;

    localparam int CLK_DIV     = 2;
    localparam int FRAME_TICKS = 4;
    localparam int LEVEL_W     = 10;
    localparam int LEVEL_MAX   = 20;
    localparam int FCNT_W      = cnt_width(FRAME_TICKS);
    localparam int FRAME_LEN   = CLK_DIV * FRAME_TICKS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    breath_env_gen_if #(.LEVEL_W(LEVEL_W), .FCNT_W(FCNT_W)) bus ();

    breath_env_gen #(
        .CLK_DIV     (CLK_DIV),
        .FRAME_TICKS (FRAME_TICKS),
        .LEVEL_W     (LEVEL_W),
        .LEVEL_MAX   (LEVEL_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       en;
        logic [7:0] step;
        logic [7:0] hh;
        logic [7:0] hl;
        int         level;
        state_e     st;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    function automatic int exp_duty(input int level);
`ifdef BREATH_GAMMA_EN
        return (level * level) >> LEVEL_W;
`else
        return level;
`endif
    endfunction

    function automatic void add(input logic en, input int step, input int hh, input int hl,
                                input int level, input state_e st);
        vec_t v;
        v.en = en; v.step = 8'(step); v.hh = 8'(hh); v.hl = 8'(hl);
        v.level = level; v.st = st;
        vecs.push_back(v);
    endfunction

    // Advance to the next frame_o pulse, at most a few frames away.
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME_LEN; i++) begin
            @(posedge clk);
            #1;
            if (bus.frame_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int k;

        // level trace: rise by 5, peak, fall, one hold-low frame, then stop
        add(1, 5, 0, 0,  5, RISE);
        add(1, 5, 0, 0, 10, RISE);
        add(1, 5, 0, 0, 15, RISE);
        add(1, 5, 0, 0, 20, HOLD_HI);
        add(1, 5, 0, 0, 20, FALL);
        add(1, 5, 0, 0, 15, FALL);
        add(1, 5, 0, 0, 10, FALL);
        add(1, 5, 0, 0,  5, FALL);
        add(1, 5, 0, 0,  0, HOLD_LO);
        add(1, 5, 0, 0,  5, RISE);
        add(0, 5, 0, 0,  5, FALL);
        add(0, 5, 0, 0,  0, HOLD_LO);
        add(0, 5, 0, 0,  0, IDLE);
        // step 7, clamped peak, 3-frame hold; hold inputs changed mid-hold
        add(1, 7, 2, 0,  7, RISE);
        add(1, 7, 2, 0, 14, RISE);
        add(1, 7, 2, 0, 20, HOLD_HI);
        add(1, 7, 0, 0, 20, HOLD_HI);
        add(1, 7, 0, 0, 20, HOLD_HI);
        add(1, 7, 0, 1, 20, FALL);
        add(1, 7, 0, 1, 13, FALL);
        add(1, 7, 0, 1,  6, FALL);
        add(1, 7, 0, 1,  0, HOLD_LO);
        add(1, 5, 0, 3,  0, HOLD_LO);
        // enable dropped mid-rise at 10
        add(1, 5, 0, 0,  5, RISE);
        add(1, 5, 0, 0, 10, RISE);
        add(0, 5, 0, 0, 10, FALL);
        add(0, 5, 0, 0,  5, FALL);
        add(0, 5, 0, 0,  0, HOLD_LO);
        add(0, 5, 0, 0,  0, IDLE);
        // step above peak from IDLE: straight to HOLD_HI
        add(1, 25, 0, 0, 20, HOLD_HI);
        add(0, 25, 0, 0, 20, FALL);
        add(0, 25, 0, 0,  0, HOLD_LO);
        add(0, 25, 0, 0,  0, IDLE);
        // step 0 acts as 1
        add(1, 0, 0, 0, 1, RISE);
        add(1, 0, 0, 0, 2, RISE);
        add(1, 0, 0, 0, 3, RISE);

        bus.en_i = 1'b0; bus.step_i = '0; bus.hold_hi_i = '0; bus.hold_lo_i = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst duty",      32'(bus.duty_o), 0);
        check("rst frame",     32'(bus.frame_o), 0);
        check("rst state",     32'(bus.state_o), 0);
        check("rst busy",      32'(bus.busy_o), 0);
        check("rst frame_cnt", 32'(bus.frame_cnt_o), 0);

        // idle timebase: pulse on every 8th edge after release
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle frame_o cyc %0d", c), 32'(bus.frame_o), 32'((c % FRAME_LEN) == 0));
        end
        check("idle duty", 32'(bus.duty_o), 0);
        check("idle busy", 32'(bus.busy_o), 0);

        // table-driven envelope
        foreach (vecs[i]) begin
            bus.en_i      = vecs[i].en;
            bus.step_i    = vecs[i].step;
            bus.hold_hi_i = vecs[i].hh;
            bus.hold_lo_i = vecs[i].hl;
            wait_frame(ok);
            check($sformatf("vec %0d frame seen", i), 32'(ok), 1);
            check($sformatf("vec %0d duty", i),  32'(bus.duty_o), 32'(exp_duty(vecs[i].level)));
            check($sformatf("vec %0d state", i), 32'(bus.state_o), 32'(vecs[i].st));
            check($sformatf("vec %0d busy", i),  32'(bus.busy_o), 32'(vecs[i].st != IDLE));
            check($sformatf("vec %0d frame_cnt", i), 32'(bus.frame_cnt_o), 0);
        end

        // one-edge reset mid-ramp (en=1, step=0 still applied)
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst duty",  32'(bus.duty_o), 0);
        check("midrst state", 32'(bus.state_o), 0);
        check("midrst busy",  32'(bus.busy_o), 0);
        check("midrst frame", 32'(bus.frame_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        ok = 1'b0;
        for (int c = 1; c <= 4 * FRAME_LEN; c++) begin
            @(posedge clk);
            #1;
            if (bus.frame_o) begin
                k = c;
                ok = 1'b1;
                break;
            end
        end
        check("postrst frame seen",    32'(ok), 1);
        check("postrst frame latency", 32'(k), 32'(FRAME_LEN));
        check("postrst duty",  32'(bus.duty_o), 32'(exp_duty(1)));
        check("postrst state", 32'(bus.state_o), 32'(RISE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
